dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words of internal storage (byte address range 0..4*DEPTH_WORDS-1).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, giving the number of extra wait-state cycles between request accept and response.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RV32I load/store width code.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  initiator accepts the response.
REQ-014 rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-015 rsp_err  output  1  misaligned, out-of-range or illegal-funct3 request.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 A request SHALL be accepted only on a rising edge where req_valid=1 and req_ready=1; on accept, req_addr, req_we, req_funct3 and req_wdata SHALL be captured and the FSM SHALL go IDLE->WAIT.
REQ-018 req_ready SHALL be registered: it SHALL be 1 only while in IDLE, SHALL be cleared on the accept edge, and SHALL be set on the edge returning to IDLE.
REQ-019 WAIT SHALL last WAIT_CYCLES+1 cycles, counted by a down-counter, and then go WAIT->RESP; rsp_valid SHALL rise exactly WAIT_CYCLES+2 edges after the accept edge (3 edges at the default).
REQ-020 rsp_valid, rsp_rdata and rsp_err SHALL be held stable in RESP until an edge with rsp_ready=1; that edge SHALL go RESP->IDLE and clear rsp_valid.
REQ-021 Legal store funct3: 000 SB, 001 SH, 010 SW. Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other code SHALL set rsp_err=1.
REQ-022 A request SHALL be misaligned when it is a halfword access with addr[0]=1, or a word access with addr[1:0]!=0; a misaligned request SHALL set rsp_err=1.
REQ-023 A request SHALL be out of range when addr[31:2] >= DEPTH_WORDS; an out-of-range request SHALL set rsp_err=1.
REQ-024 A store SHALL write only the byte lanes selected by funct3 and addr[1:0], using little-endian lane order.
REQ-025 The store write SHALL commit on the WAIT->RESP edge.
REQ-026 A store with an error SHALL NOT modify storage.
REQ-027 A store response SHALL still be returned, with rsp_rdata=0.
REQ-028 Loads SHALL extract the addressed lane(s); LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend.
REQ-029 An erroring load SHALL return rsp_rdata=0.
REQ-030 req_valid asserted while not in IDLE SHALL be ignored.
REQ-031 A load that follows a store SHALL observe the committed store data.

Reset
REQ-032 On rst_n=0 the block SHALL immediately enter IDLE and drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear the wait counter.
REQ-033 req_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-034 A reset asserted in WAIT or RESP SHALL abort the in-flight request; a pending store whose commit edge has not yet occurred SHALL NOT be written.
REQ-035 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-036 Package dmem_pkg SHALL hold the funct3 constants (SB/SH/SW/LB/LH/LW/LBU/LHU), the FSM state encoding, and the default DEPTH_WORDS and WAIT_CYCLES values.
REQ-037 Sub-module dmem_lane_align (combinational) SHALL produce the store byte-enable mask and merged write word, the load extract/extend result, and the misalign/illegal flags; dmem_responder SHALL instantiate it once.

Verification
REQ-038 SW addr 0x0, wdata 0xDDCCBBAA, then LW addr 0x0 -> rsp_rdata=0xDDCCBBAA, rsp_err=0, rsp_valid 3 cycles after each accept.
REQ-039 Then SB addr 0x1, wdata 0x000000EE; LW addr 0x0 -> 0xDDCCEEAA; LB addr 0x1 -> 0xFFFFFFEE; LBU addr 0x1 -> 0x000000EE; LHU addr 0x2 -> 0x0000DDCC.
REQ-040 SW addr 0x2, wdata 0x12345678 -> rsp_err=1; a following LW addr 0x0 -> still 0xDDCCEEAA. LW addr 4*DEPTH_WORDS -> rsp_err=1, rsp_rdata=0. funct3=011 load -> rsp_err=1.
REQ-041 Hold rsp_ready=0 for 4 cycles during a load response -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; req_ready returns 1 on the edge after rsp_ready=1.
REQ-042 Assert rst_n=0 during WAIT of SW addr 0x4, wdata 0xCAFEBABE -> outputs go to reset values at once; after release, LW addr 0x4 returns the pre-reset contents and not 0xCAFEBABE.
REQ-043 Repeat REQ-038 with WAIT_CYCLES=0 and WAIT_CYCLES=3 -> latency of 2 and 5 edges respectively.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

    // RV32I load/store width codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int DEF_DEPTH_WORDS = 256;
    localparam int DEF_WAIT_CYCLES = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Request fields captured on the accept edge
    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between an initiator and the data-memory responder.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables/merge, load extract/extend, legality checks.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_word,
    output logic [3:0]  be,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] wr_shift;
    logic [31:0] rd_shift;

    // Legality, alignment and store lane selection
    always_comb begin
        illegal  = 1'b1;
        misalign = 1'b0;
        be       = 4'b0000;
        case (funct3)
            F3_SB, F3_SH, F3_SW: illegal = 1'b0;
            F3_LBU, F3_LHU:      illegal = we;
            default:             illegal = 1'b1;
        endcase
        case (funct3[1:0])
            2'b00: begin
                be = 4'b0001 << addr_lo;
            end
            2'b01: begin
                misalign = addr_lo[0];
                be       = 4'b0011 << addr_lo;
            end
            2'b10: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
            end
            default: be = 4'b0000;
        endcase
    end

    // Merge right-aligned store data into the addressed lanes of the old word
    always_comb begin
        wr_shift = wdata << {addr_lo, 3'b000};
        wr_word  = mem_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = wr_shift[8*i +: 8];
        end
    end

    // Extract the addressed lane(s) and sign/zero extend
    always_comb begin
        rd_shift = mem_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_LB:   ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_LH:   ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_LW:   ld_data = rd_shift;
            F3_LBU:  ld_data = {24'h0, rd_shift[7:0]};
            F3_LHU:  ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: accept, wait, commit/read, hold response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic   clk,
    input  logic   rst_n,
    dmem_if.slave  bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic          ready_q, ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept, commit, in_range, err, wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   mem_word, wr_word, ld_data;
    logic [3:0]    be;
    logic          misalign, illegal;

    assign accept   = bus.req_valid && ready_q && (state_q == S_IDLE);
    assign commit   = (state_q == S_WAIT) && (cnt_q == '0);
    assign in_range = req_q.addr[31:2] < 30'(DEPTH_WORDS);
    assign idx      = req_q.addr[AW+1:2];
    assign mem_word = in_range ? mem[idx] : 32'h0;
    assign err      = illegal | misalign | ~in_range;
    assign wr_en    = commit && req_q.we && !err;

    dmem_lane_align u_align (
        .we       (req_q.we),
        .funct3   (req_q.funct3),
        .addr_lo  (req_q.addr[1:0]),
        .wdata    (req_q.wdata),
        .mem_word (mem_word),
        .be       (be),
        .wr_word  (wr_word),
        .ld_data  (ld_data),
        .misalign (misalign),
        .illegal  (illegal)
    );

    // State and registered outputs; reset aborts any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next state and wait-state down-counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_WAIT;
                cnt_d   = CNT_INIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output next values and request capture
    always_comb begin
        ready_d     = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        req_d       = req_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            req_d = '{we: bus.req_we, funct3: bus.req_funct3,
                      addr: bus.req_addr, wdata: bus.req_wdata};
        end
        if (commit) begin
            rsp_err_d   = err;
            rsp_rdata_d = (req_q.we || err) ? 32'h0 : ld_data;
        end else if (state_q == S_RESP && bus.rsp_ready) begin
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
        end
    end

    // Storage is not reset; a store lands on the WAIT->RESP edge only
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder with three wait-state variants.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  sel = 2'd0;

    logic [2:0]  rdy_v, vld_v, err_v;
    logic [31:0] rd_v [3];
    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int nvec = 0;
    int nerr = 0;

    bit [31:0] mdl [3][DEPTH];

    always #5 clk = ~clk;

    dmem_if u_if [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        assign u_if[g].req_valid  = req_valid && (sel == 2'(g));
        assign u_if[g].rsp_ready  = rsp_ready && (sel == 2'(g));
        assign u_if[g].req_we     = req_we;
        assign u_if[g].req_funct3 = req_funct3;
        assign u_if[g].req_addr   = req_addr;
        assign u_if[g].req_wdata  = req_wdata;
        assign rdy_v[g] = u_if[g].req_ready;
        assign vld_v[g] = u_if[g].rsp_valid;
        assign err_v[g] = u_if[g].rsp_err;
        assign rd_v[g]  = u_if[g].rsp_rdata;
        dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if[g])
        );
    end

    assign o_ready = rdy_v[sel];
    assign o_valid = vld_v[sel];
    assign o_err   = err_v[sel];
    assign o_rdata = rd_v[sel];

    // Reference model: byte-addressed little-endian memory with RV32I rules
    function automatic void mdl_access(input int d, input bit we, input bit [2:0] f3,
                                       input bit [31:0] a, input bit [31:0] wd,
                                       output bit [31:0] rd, output bit er);
        int size, off, w;
        bit legal, mis, oor;
        bit [31:0] v;
        size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        w     = int'(a >> 2);
        oor   = w >= DEPTH;
        er    = !legal || mis || oor;
        rd    = 32'h0;
        if (er) return;
        off = int'(a[1:0]);
        v   = mdl[d][w];
        if (we) begin
            for (int i = 0; i < size; i++) v[8*(off+i) +: 8] = wd[8*i +: 8];
            mdl[d][w] = v;
        end else begin
            v = v >> (8*off);
            if (size < 4) begin
                v = v & ((32'd1 << (8*size)) - 32'd1);
                if (!f3[2] && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            end
            rd = v;
        end
    endfunction

    // One request/response transaction with protocol checks along the way
    task automatic xact(input bit we, input bit [2:0] f3, input bit [31:0] a,
                        input bit [31:0] wd, input int hold, input bit busy,
                        output bit [31:0] rd, output bit er, output int lat);
        int n;
        rd = 0; er = 0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        n = 0;
        while (o_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        nvec++;
        if (o_ready !== 1'b1) begin
            nerr++; $display("FAIL accept_timeout: req_ready=%b required 1", o_ready);
            req_valid = 1'b0; return;
        end
        @(posedge clk); #1;
        if (busy) begin
            req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
            req_addr = $urandom; req_wdata = $urandom;
        end else req_valid = 1'b0;
        nvec++;
        if (o_ready !== 1'b0) begin
            nerr++; $display("FAIL ready_after_accept: req_ready=%b required 0", o_ready);
        end
        lat = 1;
        while (o_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
        req_valid = 1'b0;
        nvec++;
        if (o_valid !== 1'b1) begin
            nerr++; $display("FAIL rsp_timeout: rsp_valid=%b required 1", o_valid); return;
        end
        rd = o_rdata; er = o_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            nvec++;
            if (o_valid !== 1'b1 || o_rdata !== rd || o_err !== er || o_ready !== 1'b0) begin
                nerr++;
                $display("FAIL rsp_hold: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                         o_valid, o_rdata, o_err, o_ready, rd, er);
            end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        nvec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            nerr++; $display("FAIL rsp_release: valid=%b ready=%b required 0/1", o_valid, o_ready);
        end
    endtask

    task automatic test_reset;
        #12;
        nvec++;
        if (rdy_v !== 3'b000 || vld_v !== 3'b000 || err_v !== 3'b000 || o_rdata !== 32'h0) begin
            nerr++; $display("FAIL reset_vals: ready=%b valid=%b err=%b rdata=%h required 0", rdy_v, vld_v, err_v, o_rdata);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        nvec++;
        if (rdy_v !== 3'b000) begin
            nerr++; $display("FAIL ready_before_edge: ready=%b required 000", rdy_v);
        end
        @(posedge clk); #1;
        nvec++;
        if (rdy_v !== 3'b111) begin
            nerr++; $display("FAIL ready_first_edge: ready=%b required 111", rdy_v);
        end
    endtask

    task automatic test_fill;
        bit [31:0] rd, erd, wd; bit er, eer; int lat;
        sel = 2'd0;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            mdl_access(0, 1'b1, F3_SW, 32'(w*4), wd, erd, eer);
            xact(1'b1, F3_SW, 32'(w*4), wd, 0, 1'b0, rd, er, lat);
            nvec++;
            if (er !== eer || rd !== erd) begin
                nerr++; $display("FAIL fill_sw[%0d]: err=%b rdata=%h required %b/%h", w, er, rd, eer, erd);
            end
        end
    endtask

    task automatic test_directed;
        bit        t_we [11] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        bit [2:0]  t_f3 [11] = '{F3_SW, F3_LW, F3_SB, F3_LW, F3_LB, F3_LBU, F3_LHU, F3_SW, F3_LW, F3_LW, 3'b011};
        bit [31:0] t_a  [11] = '{0, 0, 1, 0, 1, 1, 2, 2, 0, 4*DEPTH, 0};
        bit [31:0] t_wd [11] = '{32'hDDCCBBAA, 0, 32'h000000EE, 0, 0, 0, 0, 32'h12345678, 0, 0, 0};
        bit [31:0] t_rd [11] = '{0, 32'hDDCCBBAA, 0, 32'hDDCCEEAA, 32'hFFFFFFEE, 32'h000000EE,
                                 32'h0000DDCC, 0, 32'hDDCCEEAA, 0, 0};
        bit        t_er [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        bit [31:0] rd, mrd; bit er, mer; int lat;
        sel = 2'd0;
        for (int i = 0; i < 11; i++) begin
            mdl_access(0, t_we[i], t_f3[i], t_a[i], t_wd[i], mrd, mer);
            xact(t_we[i], t_f3[i], t_a[i], t_wd[i], 0, 1'b0, rd, er, lat);
            nvec++;
            if (rd !== t_rd[i] || er !== t_er[i] || lat != 3) begin
                nerr++;
                $display("FAIL directed[%0d]: rdata=%h err=%b lat=%0d required %h/%b/3",
                         i, rd, er, lat, t_rd[i], t_er[i]);
            end
        end
    endtask

    task automatic test_hold;
        bit [31:0] rd, erd; bit er, eer; int lat;
        sel = 2'd0;
        mdl_access(0, 1'b0, F3_LW, 32'h0, 32'h0, erd, eer);
        xact(1'b0, F3_LW, 32'h0, 32'h0, 4, 1'b0, rd, er, lat);
        nvec++;
        if (rd !== erd || er !== eer) begin
            nerr++; $display("FAIL hold_load: rdata=%h err=%b required %h/%b", rd, er, erd, eer);
        end
    endtask

    task automatic test_random;
        bit [31:0] rd, erd, a, wd; bit er, eer, we; bit [2:0] f3; int lat;
        sel = 2'd0;
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'($urandom_range(DEPTH, DEPTH + 64)) << 2;
            else                           a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'($urandom_range(0, 3));
            wd = $urandom;
            mdl_access(0, we, f3, a, wd, erd, eer);
            xact(we, f3, a, wd, $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd, er, lat);
            nvec++;
            if (rd !== erd || er !== eer || lat != 3) begin
                nerr++;
                $display("FAIL random[%0d] we=%b f3=%b a=%h: rdata=%h err=%b lat=%0d required %h/%b/3",
                         i, we, f3, a, rd, er, lat, erd, eer);
            end
        end
    endtask

    task automatic test_reset_abort;
        bit [31:0] rd, exp_w; bit er; int lat;
        sel = 2'd0;
        exp_w = mdl[0][1];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_SW; req_addr = 32'h4; req_wdata = 32'hCAFEBABE;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        nvec++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'h0) begin
            nerr++; $display("FAIL abort_reset_vals: ready=%b valid=%b err=%b rdata=%h required 0",
                             o_ready, o_valid, o_err, o_rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (o_ready !== 1'b1) begin
            nerr++; $display("FAIL abort_ready: ready=%b required 1", o_ready);
        end
        xact(1'b0, F3_LW, 32'h4, 32'h0, 0, 1'b0, rd, er, lat);
        nvec++;
        if (rd !== exp_w || er !== 1'b0) begin
            nerr++; $display("FAIL abort_no_write: rdata=%h err=%b required %h/0", rd, er, exp_w);
        end
    endtask

    task automatic test_latency;
        bit [31:0] rd; bit er; int lat, exp_lat;
        for (int k = 1; k <= 2; k++) begin
            sel = 2'(k);
            exp_lat = (k == 1) ? 2 : 5;
            xact(1'b1, F3_SW, 32'h0, 32'hDDCCBBAA, 0, 1'b0, rd, er, lat);
            nvec++;
            if (lat != exp_lat || er !== 1'b0 || rd !== 32'h0) begin
                nerr++; $display("FAIL latency_sw[%0d]: lat=%0d err=%b rdata=%h required %0d/0/0",
                                 k, lat, er, rd, exp_lat);
            end
            xact(1'b0, F3_LW, 32'h0, 32'h0, 0, 1'b0, rd, er, lat);
            nvec++;
            if (lat != exp_lat || er !== 1'b0 || rd !== 32'hDDCCBBAA) begin
                nerr++; $display("FAIL latency_lw[%0d]: lat=%0d err=%b rdata=%h required %0d/0/ddccbbaa",
                                 k, lat, er, rd, exp_lat);
            end
        end
        sel = 2'd0;
    endtask

    initial begin
        test_reset;
        test_fill;
        test_directed;
        test_hold;
        test_random;
        test_reset_abort;
        test_latency;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
